// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall and run/halt sequencing for a 5-stage MIPS32 pipe without forwarding.
// Define WB_WRITE_FIRST_EN when the register file is write-first, so the WB entry is ignored.
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W  = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic [31:0]            id_ir,
    input  logic                   id_valid,
    output logic                   fetch_en,
    output logic                   id_hold,
    output logic                   idex_bubble,
    output logic                   busy,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;
    state_t        state;
    logic [5:0]    sb_ex, sb_mem, sb_wb;
    logic [DW-1:0] drain_cnt;
    logic [5:0]    op;
    logic [4:0]    rs, rt, rd, dest, rs_src, rt_src;
    logic          is_r, is_lw, is_addi, is_sw, has_dest, hazard, run, unused_ir;
    assign op        = id_ir[31:26];
    assign rs        = id_ir[25:21];
    assign rt        = id_ir[20:16];
    assign rd        = id_ir[15:11];
    assign unused_ir = ^id_ir[10:0];
    assign is_r      = op == 6'b000000;
    assign is_lw     = op == 6'b100011;
    assign is_addi   = op == 6'b001000;
    assign is_sw     = op == 6'b101011;
    // An unused source is presented as r0, which never matches.
    assign rs_src    = (is_r | is_lw | is_addi | is_sw) ? rs : 5'd0;
    assign rt_src    = (is_r | is_sw) ? rt : 5'd0;
    assign dest      = is_r ? rd : (is_lw | is_addi) ? rt : 5'd0;
    assign has_dest  = dest != 5'd0;
    function automatic logic hit(input logic [5:0] e, input logic [4:0] a, input logic [4:0] b);
        return e[5] && ((a != 5'd0 && e[4:0] == a) || (b != 5'd0 && e[4:0] == b));
    endfunction
`ifdef WB_WRITE_FIRST_EN
    assign hazard = id_valid && (hit(sb_ex, rs_src, rt_src) || hit(sb_mem, rs_src, rt_src));
`else
    assign hazard = id_valid && (hit(sb_ex, rs_src, rt_src) || hit(sb_mem, rs_src, rt_src) ||
                                 hit(sb_wb, rs_src, rt_src));
`endif
    assign run         = state == RUN;
    assign fetch_en    = run && !hazard;
    assign id_hold     = (state == DRAIN) || (run && hazard);
    assign idex_bubble = id_hold;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: begin
                    sb_wb  <= sb_mem;
                    sb_mem <= sb_ex;
                    sb_ex  <= hazard ? 6'd0 : {id_valid && has_dest, dest};
                    if (hazard && !(&stall_cnt))
                        stall_cnt <= stall_cnt + 1'b1;
                    if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    sb_wb     <= sb_mem;
                    sb_mem    <= sb_ex;
                    sb_ex     <= '0;
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state  <= HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        sb_ex  <= '0;
                        sb_mem <= '0;
                        sb_wb  <= '0;
                    end
                end
                HALTED: if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    halted <= 1'b0;
                    sb_ex  <= '0;
                    sb_mem <= '0;
                    sb_wb  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stream of IF/ID contents with queued expected control outputs.
module tb_pipe_hazard_ctrl;
`ifdef WB_WRITE_FIRST_EN
    localparam int N = 2;
`else
    localparam int N = 3;
`endif
    localparam logic [31:0] NOP   = 32'h00000000;
    localparam logic [31:0] ADDI1 = 32'h20010005;
    localparam logic [31:0] ADDI2 = 32'h20020007;
    localparam logic [31:0] ADD3  = 32'h00221820;
    localparam logic [31:0] LW4   = 32'h8C040000;
    localparam logic [31:0] SW4   = 32'hAC040004;
    localparam logic [31:0] ADD6  = 32'h00843020;
    localparam logic [31:0] ADDI0 = 32'h20000001;
    localparam logic [31:0] ADD5  = 32'h00002820;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt_req = 1'b0, id_valid = 1'b0;
    logic [31:0] id_ir = '0;
    logic        fetch_en, id_hold, idex_bubble, busy, halted;
    logic [15:0] stall_cnt;
    logic [20:0] exp_q[$];
    int          tests = 0, fails = 0;
    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .id_ir(id_ir),
        .id_valid(id_valid), .fetch_en(fetch_en), .id_hold(id_hold), .idex_bubble(idex_bubble),
        .busy(busy), .halted(halted), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag);
        logic [20:0] got, e;
        e   = exp_q.pop_front();
        got = {fetch_en, id_hold, idex_bubble, busy, halted, stall_cnt};
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s got fe/hold/bub/busy/halted=%b stall=%0d exp %b stall=%0d",
                   tag, got[20:16], got[15:0], e[20:16], e[15:0]);
        end
    endtask
    task automatic step(input string tag, input logic [31:0] ir, input logic v, input logic s,
                        input logic h, input logic [4:0] ctl, input int sc);
        @(negedge clk);
        id_ir = ir; id_valid = v; start = s; halt_req = h;
        exp_q.push_back({ctl, sc[15:0]});
        #1 check(tag);
    endtask
    initial begin
        #1;
        exp_q.push_back(21'd0);
        check("reset");
        @(negedge clk) rst_n = 1'b1;
        step("idle_halt_ignored", NOP, 1, 0, 1, 5'b00000, 0);
        step("idle_start", NOP, 1, 1, 0, 5'b00000, 0);
        step("run_addi1", ADDI1, 1, 0, 0, 5'b10010, 0);
        step("run_addi2", ADDI2, 1, 0, 0, 5'b10010, 0);
        for (int i = 0; i < 3; i++) step("nop_a", NOP, 1, 0, 0, 5'b10010, 0);
        step("raw_producer", ADDI1, 1, 0, 0, 5'b10010, 0);
        for (int k = 0; k < N; k++) step("raw_stall", ADD3, 1, 0, 0, 5'b01110, k);
        step("raw_issue", ADD3, 1, 0, 0, 5'b10010, N);
        step("invalid_no_stall", ADD3, 0, 0, 0, 5'b10010, N);
        for (int i = 0; i < 3; i++) step("nop_b", NOP, 1, 0, 0, 5'b10010, N);
        step("lw_issue", LW4, 1, 0, 0, 5'b10010, N);
        for (int k = 0; k < N; k++) step("load_use_stall", SW4, 1, 0, 0, 5'b01110, N + k);
        step("sw_issue", SW4, 1, 0, 0, 5'b10010, 2 * N);
        step("sw_no_dest", ADD6, 1, 0, 0, 5'b10010, 2 * N);
        step("r0_addi", ADDI0, 1, 0, 0, 5'b10010, 2 * N);
        step("r0_add", ADD5, 1, 0, 0, 5'b10010, 2 * N);
        step("halt_producer", ADDI1, 1, 0, 0, 5'b10010, 2 * N);
        step("halt_in_stall", ADD3, 1, 1, 1, 5'b01110, 2 * N);
        for (int k = 0; k < 3; k++) step("drain", ADD3, 1, 1, 0, 5'b01110, 2 * N + 1);
        step("halted", ADD3, 1, 0, 0, 5'b00001, 2 * N + 1);
        step("halted_start", ADD3, 1, 1, 1, 5'b00001, 2 * N + 1);
        step("restart_clear", ADD3, 1, 0, 0, 5'b10010, 2 * N + 1);
        step("pre_halt_issue", NOP, 1, 0, 1, 5'b10010, 2 * N + 1);
        step("mid_drain", NOP, 1, 0, 0, 5'b01110, 2 * N + 1);
        #2 rst_n = 1'b0;
        exp_q.push_back(21'd0);
        #1 check("async_reset_mid_drain");
        @(negedge clk) rst_n = 1'b1;
        step("post_reset_idle", NOP, 1, 1, 0, 5'b00000, 0);
        step("post_reset_run", NOP, 1, 0, 0, 5'b10010, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB).
- Keeps a scoreboard of destination registers for instructions in EX, MEM and WB, and detects RAW hazards against the instruction in ID.
- The datapath has no forwarding, so on a hazard the block holds IF/ID and injects a bubble into ID/EX.
- Owns run/halt sequencing: start from idle, then drain the pipeline on a halt request.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- DRAIN_CYCLES, 3, cycles spent in DRAIN (EX, MEM, WB emptying).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins execution from IDLE or HALTED.
- halt_req  in  1  single-cycle pulse; stop fetching and drain.
- id_ir  in  32  instruction currently held in the IF/ID register.
- id_valid  in  1  id_ir holds a real instruction, not reset junk.
- fetch_en  out  1  advances PC and loads IF/ID.
- id_hold  out  1  IF/ID keeps its value; ID/EX must not load id_ir.
- idex_bubble  out  1  ID/EX loads NOP (IR=0, ALUop=3'b111 meaning no writeback).
- busy  out  1  state is RUN or DRAIN.
- halted  out  1  state is HALTED.
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, scoreboard cleared, fetch_en=0, id_hold=0, idex_bubble=0, busy=0, halted=0, stall_cnt=0.
- Decode of id_ir, combinational, used for both source and destination fields:
  - op 000000 (R-type): srcs rs=[25:21] and rt=[20:16]; dest rd=[15:11].
  - op 100011 (LW): src rs; dest rt.
  - op 001000 (ADDI): src rs; dest rt.
  - op 101011 (SW): srcs rs and rt; no dest.
  - Any other opcode: no srcs, no dest.
  - A dest of 0 is recorded as no dest.
- Scoreboard: three entries {v, dest[4:0]}: SB_EX, SB_MEM, SB_WB. Every clock in RUN or DRAIN they shift EX->MEM->WB and the old WB entry is discarded.
- hazard = id_valid AND some valid entry (EX, MEM or WB) has dest equal to a used source, with source != 0.
  - WB is included because the register file writes and ID reads on the same edge, so ID sees the old value.
- States:
  - IDLE: all outputs 0. start -> RUN.
  - RUN, no hazard: fetch_en=1, id_hold=0, idex_bubble=0. Next SB_EX = {id_valid AND has_dest, dest}.
  - RUN, hazard: fetch_en=0, id_hold=1, idex_bubble=1. Next SB_EX = invalid. stall_cnt increments, saturating at all-ones.
  - RUN + halt_req: next state DRAIN. The current cycle still issues or stalls as above.
  - DRAIN: fetch_en=0, id_hold=1, idex_bubble=1. Scoreboard shifts with invalid fill. After DRAIN_CYCLES cycles -> HALTED with scoreboard all-invalid.
  - HALTED: halted=1, all else 0. start -> RUN with the scoreboard empty.
- Output timing: fetch_en, id_hold and idex_bubble are combinational from state, scoreboard and id_ir (same-cycle response). busy, halted and stall_cnt are registered.
- Simultaneous start and halt_req: halt_req wins in RUN; start is ignored in RUN and DRAIN; halt_req is ignored in IDLE and HALTED.
- Worst-case RAW back-to-back (producer then consumer): 3 stall cycles. With one independent instruction between them: 2.
- Load-use hazard needs no extra rule; it is covered by the same window.
- Reset mid-stall or mid-drain: immediate return to IDLE; stall_cnt cleared.

Optional Feature:
- Macro WB_WRITE_FIRST_EN.
- Defined: the register file is write-first, so the SB_WB entry is excluded from the hazard compare. Worst-case back-to-back stall becomes 2 cycles.
- Undefined: all three entries are compared (default).

Test Plan:
- Reset then start; stream ADDI r1,r0,5 / ADDI r2,r0,7 (independent) -> fetch_en=1 every cycle, idex_bubble never 1, stall_cnt=0.
- ADD r3,r1,r2 immediately after ADDI r1,r0,5 -> idex_bubble=1 for exactly 3 cycles (2 with WB_WRITE_FIRST_EN), then issue; stall_cnt=3.
- LW r4,0(r0) then SW r4,4(r0) -> 3 stall cycles; after that, SB_EX holds no dest for the SW.
- ADDI r0,r0,1 followed by ADD r5,r0,r0 -> no stall (r0 excluded); stall_cnt unchanged.
- halt_req during a stall -> DRAIN for 3 cycles, then halted=1 and busy=0; start -> RUN with the old hazard cleared.
- Assert rst_n=0 mid-DRAIN, release, then start -> state passes through IDLE; fetch_en=1 on the first RUN cycle; stall_cnt=0.
